// File: rtl/sprite_pkg.sv
// Shared types for the per-line sprite scanner: FIFO entry layout, FSM states, slot byte offsets.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package sprite_pkg;

    // One sprite accepted for the upcoming line, as handed to the renderer
    typedef struct packed {
        logic [7:0] code;
        logic [7:0] attr;
        logic [7:0] x;
        logic [3:0] row;
    } spr_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_Y,
        CHK,
        RD_CODE,
        RD_ATTR,
        RD_X,
        PUSH,
        DONE
    } state_e;

    // Byte offsets within a 4-byte sprite slot
    localparam logic [1:0] BYTE_Y    = 2'd0;
    localparam logic [1:0] BYTE_CODE = 2'd1;
    localparam logic [1:0] BYTE_ATTR = 2'd2;
    localparam logic [1:0] BYTE_X    = 2'd3;

endpackage

// File: rtl/sprite_fifo.sv
// Small synchronous FIFO of sprite entries, all state gated by the pixel clock enable.
// Latency: an entry pushed on one cen is visible at the head on the next cen.
// Backpressure: pushes while full are dropped, pops while empty are ignored; flush wins over both.
module sprite_fifo
    import sprite_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk_49m,
    input  logic       reset_n,
    input  logic       cen,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  spr_entry_t wdata,
    output spr_entry_t rdata,
    output logic       full,
    output logic       empty
);
    localparam int PW = $clog2(DEPTH);

    spr_entry_t  mem_q [DEPTH];
    logic [PW:0] wr_q;
    logic [PW:0] rd_q;
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_q[PW-1:0]];

    // Entry storage; contents are only observed while the FIFO is non-empty
    always_ff @(posedge clk_49m) begin
        if (cen && do_push) begin
            mem_q[wr_q[PW-1:0]] <= wdata;
        end
    end

    // Read/write pointers; flush empties the FIFO at the start of every scan
    always_ff @(posedge clk_49m) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (cen) begin
            if (flush) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (do_push) wr_q <= wr_q + 1'b1;
                if (do_pop)  rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Walks sprite RAM once per line, applies the 503 vertical-hit rule and queues hits for the renderer (SPRITE_VFLIP_EN adds attr[7] row flip).
// Latency: miss slot 2 cen, hit slot 5 cen (next slot's Y read overlaps PUSH); done one cen after the last slot.
// Backpressure: renderer drains via obj_valid/obj_ready; a hit with the FIFO full ends the scan and sets overflow.
module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES  = 24,
    parameter int MAX_PER_LINE = 8,
    parameter int AW           = $clog2(NUM_SPRITES*4)
) (
    input  logic          clk_49m,
    input  logic          reset_n,
    input  logic          cen,
    input  logic          line_start,
    input  logic [7:0]    vcnt,
    output logic [AW-1:0] spr_addr,
    output logic          spr_rd,
    input  logic [7:0]    spr_data,
    output logic          obj_valid,
    input  logic          obj_ready,
    output logic [7:0]    obj_code,
    output logic [7:0]    obj_attr,
    output logic [7:0]    obj_x,
    output logic [3:0]    obj_row,
    output logic          busy,
    output logic          done,
    output logic          overflow
);
    localparam int SW = $clog2(NUM_SPRITES + 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SPRITES - 1);
    localparam logic [SW-1:0] END_SLOT  = SW'(NUM_SPRITES);

    state_e        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [7:0]    vcnt_q, vcnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_q, rd_d;
    logic [3:0]    row_q, row_d;
    logic [7:0]    code_q, code_d;
    logic [7:0]    attr_q, attr_d;
    logic [7:0]    x_q, x_d;
    logic          ovf_q, ovf_d;

    logic          fifo_push, fifo_flush, fifo_full, fifo_empty;
    logic [7:0]    sum;
    logic          hit;
    spr_entry_t    wr_entry, head;

    function automatic logic [AW-1:0] addr_of(input logic [SW-1:0] s, input logic [1:0] b);
        return AW'({s, b});
    endfunction

    // 503 rule: the sprite covers this line when Y + line lands in the top 16 values
    assign sum = spr_data + vcnt_q;
    assign hit = (sum[7:4] == 4'hF);

    // Scan sequencing; the RAM address for a state is registered on entry to it,
    // so each state sees the data requested one state earlier
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        vcnt_d     = vcnt_q;
        addr_d     = addr_q;
        rd_d       = 1'b0;
        row_d      = row_q;
        code_d     = code_q;
        attr_d     = attr_q;
        x_d        = x_q;
        ovf_d      = ovf_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        if (line_start) begin
            // Start and mid-scan abort behave identically: fresh scan from slot 0
            state_d    = RD_Y;
            slot_d     = '0;
            vcnt_d     = vcnt;
            ovf_d      = 1'b0;
            fifo_flush = 1'b1;
            addr_d     = addr_of('0, BYTE_Y);
            rd_d       = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                RD_Y: begin
                    // Speculatively fetch the code byte while Y is checked
                    state_d = CHK;
                    addr_d  = addr_of(slot_q, BYTE_CODE);
                    rd_d    = 1'b1;
                end
                CHK: begin
                    row_d = sum[3:0];
                    if (hit && !fifo_full) begin
                        state_d = RD_CODE;
                        addr_d  = addr_of(slot_q, BYTE_ATTR);
                        rd_d    = 1'b1;
                    end else if (hit) begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else if (slot_q == LAST_SLOT) begin
                        state_d = DONE;
                    end else begin
                        slot_d  = slot_q + 1'b1;
                        addr_d  = addr_of(slot_q + 1'b1, BYTE_Y);
                        rd_d    = 1'b1;
                        state_d = RD_Y;
                    end
                end
                RD_CODE: begin
                    code_d  = spr_data;
                    addr_d  = addr_of(slot_q, BYTE_X);
                    rd_d    = 1'b1;
                    state_d = RD_ATTR;
                end
                RD_ATTR: begin
                    attr_d  = spr_data;
                    state_d = RD_X;
                end
                RD_X: begin
                    // Next slot's Y read is issued here so PUSH doubles as its RD_Y
                    x_d     = spr_data;
                    slot_d  = slot_q + 1'b1;
                    state_d = PUSH;
                    if (slot_q != LAST_SLOT) begin
                        addr_d = addr_of(slot_q + 1'b1, BYTE_Y);
                        rd_d   = 1'b1;
                    end
                end
                PUSH: begin
                    fifo_push = 1'b1;
                    if (slot_q == END_SLOT) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_of(slot_q, BYTE_CODE);
                        rd_d    = 1'b1;
                        state_d = CHK;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Scan state and registered RAM interface, advancing only on pixel enables
    always_ff @(posedge clk_49m) begin
        if (!reset_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            vcnt_q  <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            row_q   <= '0;
            code_q  <= '0;
            attr_q  <= '0;
            x_q     <= '0;
            ovf_q   <= 1'b0;
        end else if (cen) begin
            state_q <= state_d;
            slot_q  <= slot_d;
            vcnt_q  <= vcnt_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            row_q   <= row_d;
            code_q  <= code_d;
            attr_q  <= attr_d;
            x_q     <= x_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry assembly; the optional flip is folded in before queuing
    always_comb begin
        wr_entry.code = code_q;
        wr_entry.attr = attr_q;
        wr_entry.x    = x_q;
`ifdef SPRITE_VFLIP_EN
        wr_entry.row  = row_q ^ {4{attr_q[7]}};
`else
        wr_entry.row  = row_q;
`endif
    end

    sprite_fifo #(
        .DEPTH (MAX_PER_LINE)
    ) u_fifo (
        .clk_49m (clk_49m),
        .reset_n (reset_n),
        .cen     (cen),
        .push    (fifo_push),
        .pop     (obj_valid && obj_ready),
        .flush   (fifo_flush),
        .wdata   (wr_entry),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Head fields are forced to zero when nothing is queued
    assign obj_valid = !fifo_empty;
    assign obj_code  = obj_valid ? head.code : 8'h00;
    assign obj_attr  = obj_valid ? head.attr : 8'h00;
    assign obj_x     = obj_valid ? head.x    : 8'h00;
    assign obj_row   = obj_valid ? head.row  : 4'h0;

    assign spr_addr  = addr_q;
    assign spr_rd    = rd_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign overflow  = ovf_q;

endmodule
